// File: rtl/gps_iq_sched.sv
// Correlator dump scheduler: serves one channel at a time, shifting its I/Q accumulators
// out MSB first and presenting each assembled word on a valid/ready handshake.
module gps_iq_sched #(
    parameter int NCHAN      = 12,
    parameter int INTEG_BITS = 18,
    parameter int NWORDS     = 6,
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCHAN-1:0]      ms0,
    input  logic [NCHAN-1:0]      sout,
    output logic [NCHAN-1:0]      shift,
    input  logic                  sched_en,
    output logic [INTEG_BITS-1:0] iq_data,
    output logic [CW-1:0]         iq_chan,
    output logic [IW-1:0]         iq_idx,
    output logic                  iq_last,
    output logic                  iq_valid,
    input  logic                  iq_ready,
    output logic [NCHAN-1:0]      ovr,
    input  logic [NCHAN-1:0]      ovr_clr
);
    localparam int BW = (INTEG_BITS > 1) ? $clog2(INTEG_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(INTEG_BITS - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
    localparam logic [CW-1:0] LAST_CHAN = CW'(NCHAN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    state_t           state;
    logic [NCHAN-1:0] ms0_d1, ms0_d2;
    logic [NCHAN-1:0] pending;
    logic [CW-1:0]    last_gnt;
    logic [BW-1:0]    bit_cnt;

    logic [NCHAN-1:0] req, busy_oh, chan_oh, pick_oh;
    logic [NCHAN-1:0] pending_nxt, ovr_nxt;
    logic [CW-1:0]    pick;
    logic             found, grant_now;
    int               cand;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        req     = pending | ms0_d2;
        busy_oh = '0;
        chan_oh = '0;
        pick_oh = '0;
        pick    = '0;
        found   = 1'b0;
        cand    = 0;
        chan_oh[iq_chan] = 1'b1;
        if (state != IDLE) busy_oh[iq_chan] = 1'b1;

        // Round-robin search starting one past the channel granted last.
        for (int k = 0; k < NCHAN; k++) begin
            cand = int'(last_gnt) + 1 + k;
            if (cand >= NCHAN) cand = cand - NCHAN;
            if (!found && req[cand]) begin
                pick  = CW'(cand);
                found = 1'b1;
            end
        end

        grant_now = (state == IDLE) && sched_en && found;
        if (grant_now) pick_oh[pick] = 1'b1;

        // A pulse landing on an already-pending granted channel leaves one dump still owed.
        pending_nxt = ((pending | ms0_d2) & ~pick_oh) | (pending & ms0_d2 & pick_oh);
        ovr_nxt     = (ovr & ~ovr_clr) | (ms0_d2 & (pending | busy_oh));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ms0_d1   <= '0;
            ms0_d2   <= '0;
            pending  <= '0;
            ovr      <= '0;
            last_gnt <= LAST_CHAN;
            bit_cnt  <= '0;
            shift    <= '0;
            iq_data  <= '0;
            iq_chan  <= '0;
            iq_idx   <= '0;
            iq_last  <= 1'b0;
            iq_valid <= 1'b0;
        end else begin
            ms0_d1  <= ms0;
            ms0_d2  <= ms0_d1;
            pending <= pending_nxt;
            ovr     <= ovr_nxt;

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        iq_chan  <= pick;
                        last_gnt <= pick;
                        iq_idx   <= '0;
                        bit_cnt  <= '0;
                        iq_data  <= '0;
                        shift    <= pick_oh;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    iq_data <= {iq_data[INTEG_BITS-2:0], sout[iq_chan]};
                    if (bit_cnt == LAST_BIT) begin
                        shift    <= '0;
                        iq_valid <= 1'b1;
                        iq_last  <= (iq_idx == LAST_IDX);
                        state    <= PUSH;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                PUSH: begin
                    if (iq_ready) begin
                        iq_valid <= 1'b0;
                        iq_last  <= 1'b0;
                        if (iq_last) begin
                            state <= IDLE;
                        end else begin
                            iq_idx  <= iq_idx + 1'b1;
                            bit_cnt <= '0;
                            shift   <= chan_oh;
                            state   <= SHIFT;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gps_iq_sched.sv
// Directed bench for gps_iq_sched (NCHAN=4, INTEG_BITS=8, NWORDS=6) with a loaded-shift-register
// sout model and a transfer-level scoreboard of expected words.
`timescale 1ns/1ps
module tb_gps_iq_sched;
    localparam int NCHAN = 4;
    localparam int IB    = 8;
    localparam int NW    = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ms0, sout, shift, ovr, ovr_clr;
    logic       sched_en, iq_ready, iq_last, iq_valid;
    logic [7:0] iq_data;
    logic [1:0] iq_chan;
    logic [2:0] iq_idx;

    always #5 clk = ~clk;

    gps_iq_sched #(.NCHAN(NCHAN), .INTEG_BITS(IB), .NWORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .ms0(ms0), .sout(sout), .shift(shift),
        .sched_en(sched_en), .iq_data(iq_data), .iq_chan(iq_chan), .iq_idx(iq_idx),
        .iq_last(iq_last), .iq_valid(iq_valid), .iq_ready(iq_ready),
        .ovr(ovr), .ovr_clr(ovr_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Preloaded correlator contents: byte w of dump g for channel c.
    function automatic logic [7:0] pattern(input int c, input int g, input int w);
        logic [7:0] k;
        k = {c[1:0], g[1:0], w[3:0]};
        return 8'h5A ^ k;
    endfunction

    function automatic logic [47:0] dump_bits(input int c, input int g);
        logic [47:0] v;
        v = '0;
        for (int w = 0; w < NW; w++) v = {v[39:0], pattern(c, g, w)};
        return v;
    endfunction

    logic [47:0] shreg [4];
    int          scnt  [4];
    int          sgen  [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                shreg[c] <= dump_bits(c, 0);
                scnt[c]  <= 0;
                sgen[c]  <= 0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (shift[c]) begin
                    if (scnt[c] == NW * IB - 1) begin
                        shreg[c] <= dump_bits(c, sgen[c] + 1);
                        sgen[c]  <= sgen[c] + 1;
                        scnt[c]  <= 0;
                    end else begin
                        shreg[c] <= shreg[c] << 1;
                        scnt[c]  <= scnt[c] + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        sout = '0;
        for (int c = 0; c < NCHAN; c++) sout[c] = shreg[c][47];
    end

    typedef struct {
        int         chan;
        int         idx;
        logic [7:0] data;
        logic       last;
    } word_t;

    word_t      exp_q[$];
    word_t      got_e;
    logic [7:0] got_data[$];
    int         got_chan[$];
    int         got_cyc[$];

    task automatic push_dump(input int c, input int g, input int nw);
        word_t e;
        for (int w = 0; w < nw; w++) begin
            e.chan = c;
            e.idx  = w;
            e.data = pattern(c, g, w);
            e.last = (w == NW - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard and per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("shift_at_most_one", 32'($countones(shift) <= 1), 32'(1));
            if (iq_valid) check("shift_during_push", 32'(shift), 32'(0));
            if (iq_valid && iq_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 32'(iq_chan), 32'hFFFF_FFFF);
                end else begin
                    got_e = exp_q.pop_front();
                    check("xfer_chan", 32'(iq_chan), 32'(got_e.chan));
                    check("xfer_idx",  32'(iq_idx),  32'(got_e.idx));
                    check("xfer_data", 32'(iq_data), 32'(got_e.data));
                    check("xfer_last", 32'(iq_last), 32'(got_e.last));
                end
                got_data.push_back(iq_data);
                got_chan.push_back(int'(iq_chan));
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ms0     = '0;
        ovr_clr = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_ms0(input logic [3:0] m);
        ms0 = m;
        tick();
        ms0 = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'(0));
        repeat (3) tick();
        check("idle_after_drain", 32'({iq_valid, shift}), 32'(0));
    endtask

    task automatic wait_shift(input int ch, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (shift[ch]) begin
                at = cyc;
                break;
            end
        end
        check("shift_timeout", 32'(at >= 0), 32'(1));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0, f, base, n;
        ms0      = '0;
        ovr_clr  = '0;
        sched_en = 1'b1;
        iq_ready = 1'b1;

        // Reset state and a single dump: latency, length, preloaded bytes.
        do_reset();
        check("rst_shift",    32'(shift),    32'(0));
        check("rst_valid",    32'(iq_valid), 32'(0));
        check("rst_data",     32'(iq_data),  32'(0));
        check("rst_chan",     32'(iq_chan),  32'(0));
        check("rst_idx",      32'(iq_idx),   32'(0));
        check("rst_last",     32'(iq_last),  32'(0));
        check("rst_ovr",      32'(ovr),      32'(0));
        base = got_cyc.size();
        push_dump(2, 0, NW);
        t0 = cyc;
        pulse_ms0(4'b0100);
        wait_shift(2, 20, f);
        check("first_shift_latency", 32'(f - t0), 32'(3));
        wait_drain(100);
        check("dump1_words",   32'(got_cyc.size()), 32'(base + 6));
        check("dump1_cycles",  32'(got_cyc[base + 5] - f + 1), 32'(54));
        check("dump1_word0",   32'(got_data[base]),     32'h0000_00DA);
        check("dump1_word5",   32'(got_data[base + 5]), 32'h0000_00DF);

        // Three simultaneous epochs: round-robin order 0, 1, 3 back to back.
        do_reset();
        base = got_cyc.size();
        push_dump(0, 0, NW);
        push_dump(1, 0, NW);
        push_dump(3, 0, NW);
        pulse_ms0(4'b1011);
        wait_drain(300);
        check("rr_first",  32'(got_chan[base]),      32'(0));
        check("rr_second", 32'(got_chan[base + 6]),  32'(1));
        check("rr_third",  32'(got_chan[base + 12]), 32'(3));
        check("rr_gap_01", 32'(got_cyc[base + 6] - got_cyc[base + 5]),   32'(10));
        check("rr_gap_13", 32'(got_cyc[base + 12] - got_cyc[base + 11]), 32'(10));
        check("rr_no_ovr", 32'(ovr), 32'(0));

        // Back-pressure on word 2: everything holds for 20 cycles.
        do_reset();
        push_dump(0, 0, NW);
        pulse_ms0(4'b0001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(shift != '0 && iq_idx == 3'd2) && n < 60);
        check("stall_reach_idx2", 32'(iq_idx), 32'(2));
        iq_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iq_valid && n < 20);
        check("stall_valid_seen", 32'(iq_valid), 32'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(iq_valid), 32'(1));
            check("stall_data",  32'(iq_data),  32'h0000_0058);
            check("stall_idx",   32'(iq_idx),   32'(2));
            check("stall_shift", 32'(shift),    32'(0));
        end
        iq_ready = 1'b1;
        wait_drain(100);

        // Re-trigger of the channel being dumped: overrun, one extra dump, then clear.
        do_reset();
        push_dump(1, 0, NW);
        push_dump(1, 1, NW);
        pulse_ms0(4'b0010);
        wait_shift(1, 20, f);
        repeat (10) tick();
        pulse_ms0(4'b0010);
        repeat (4) tick();
        check("ovr_set_busy", 32'(ovr), 32'(4'b0010));
        wait_drain(300);
        check("ovr_sticky", 32'(ovr), 32'(4'b0010));
        ovr_clr = 4'b0010;
        tick();
        ovr_clr = '0;
        check("ovr_cleared", 32'(ovr), 32'(0));

        // Delayed epoch on the completion cycle, with a clear in the same cycle.
        do_reset();
        push_dump(1, 0, NW);
        push_dump(1, 1, NW);
        pulse_ms0(4'b0010);
        wait_shift(1, 20, f);
        repeat (51) @(posedge clk);
        #1;
        ms0 = 4'b0010;
        tick();
        ms0 = '0;
        tick();
        check("final_push_state", 32'({iq_valid, iq_last}), 32'(2'b11));
        ovr_clr = 4'b0010;
        tick();
        ovr_clr = '0;
        check("ovr_set_beats_clr", 32'(ovr), 32'(4'b0010));
        wait_drain(200);

        // Grants blocked while disabled, then served 1 then 2.
        do_reset();
        sched_en = 1'b0;
        pulse_ms0(4'b0110);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("disabled_shift", 32'(shift),    32'(0));
            check("disabled_valid", 32'(iq_valid), 32'(0));
        end
        check("disabled_ovr", 32'(ovr), 32'(0));
        base = got_cyc.size();
        push_dump(1, 0, NW);
        push_dump(2, 0, NW);
        sched_en = 1'b1;
        wait_drain(300);
        check("enable_first",  32'(got_chan[base]),     32'(1));
        check("enable_second", 32'(got_chan[base + 6]), 32'(2));

        // Reset during SHIFT of word 3 aborts the dump.
        do_reset();
        base = got_cyc.size();
        push_dump(3, 0, 3);
        pulse_ms0(4'b1000);
        n = 0;
        while (got_cyc.size() < base + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_three_words", 32'(got_cyc.size()), 32'(base + 3));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(shift[3] && iq_idx == 3'd3) && n < 10);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_shift", 32'(shift),    32'(0));
        check("abort_valid", 32'(iq_valid), 32'(0));
        check("abort_data",  32'(iq_data),  32'(0));
        check("abort_chan",  32'(iq_chan),  32'(0));
        check("abort_idx",   32'(iq_idx),   32'(0));
        check("abort_last",  32'(iq_last),  32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("post_abort_valid", 32'(iq_valid), 32'(0));
        end
        check("post_abort_words", 32'(got_cyc.size()), 32'(base + 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
